aes: RTL and testbench
======================

AES -- requirements
Module: aes

Interface
- REQ-001 SHALL have parameter KEY, default 128'h2b7e151628aed2a6abf7158809cf4f3c, the fixed AES-128 cipher key.
- REQ-002 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
- REQ-003 SHALL have port resetn, input, 1 bit: synchronous, active-low reset; clock is clock.
- REQ-004 SHALL have port enable, input, 1 bit: when 1, perform one round this cycle.
- REQ-005 SHALL have port i_text, input, 128 bits: round input state.
- REQ-006 SHALL have port key, input, 128 bits: current round key; the parent feeds back Rkey.
- REQ-007 SHALL have port round, input, 4 bits: index of the round key on key (0..9).
- REQ-008 SHALL have port o_text, output, 128 bits, registered: round output state.
- REQ-009 SHALL have port Rkey, output, 128 bits, registered: next round key.

Function
- REQ-010 SHALL use FIPS-197 byte order: bits [127:120] = byte 0 (row 0, col 0); column-major, 4 bytes per column.
- REQ-011 SHALL compute the next key as nk = KeyExpansion(key, Rcon[round+1]), with Rcon = 01,02,04,08,10,20,40,80,1b,36.
- REQ-011a SHALL form each nk word as w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon, then wi' = wi ^ w(i-1)'.
- REQ-012 SHALL, on a clock edge with enable=1 and round in 0..8, load o_text with the full round: SubBytes, ShiftRows, MixColumns, AddRoundKey(nk).
- REQ-012a SHALL, in that same case, load Rkey with nk.
- REQ-013 SHALL, on a clock edge with enable=1 and round=9, load o_text with the final round: SubBytes, ShiftRows, AddRoundKey(nk), no MixColumns.
- REQ-013a SHALL, in that same case, reload Rkey with KEY, ready for the next block.
- REQ-014 SHALL hold o_text and Rkey unchanged when enable=0.
- REQ-014a SHALL hold o_text and Rkey unchanged when enable=1 and round is 10..15.
- REQ-015 SHALL have a latency of 1 clock per round, with no combinational path from any input to o_text or Rkey.
- REQ-016 SHALL NOT perform the initial AddRoundKey; the caller supplies i_text = plaintext ^ Rkey at round 0.
- REQ-017 SHALL implement SubBytes and SubWord with the standard AES S-box (256x8 ROM), using 16 state instances and 4 key instances.
- REQ-018 SHALL implement MixColumns over GF(2^8) with polynomial 0x11b: xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
- REQ-019 SHALL take i_text and key from the same cycle; back-to-back enables with feedback SHALL chain rounds without bubbles.
- REQ-020 SHALL NOT implement decryption.
- REQ-020a SHALL have no busy or handshake signal; the module is always ready.

Reset
- REQ-021 SHALL, on clock edges with resetn=0, set o_text = 0 and Rkey = KEY; reset SHALL take priority over enable.
- REQ-022 SHALL, when reset is asserted mid-encryption, abandon the encryption in progress.
- REQ-022a SHALL, after that reset, start the next round-0 operation from KEY.

Verification
- REQ-023 Reset -> o_text = 0, Rkey = 2b7e151628aed2a6abf7158809cf4f3c.
- REQ-024 One round: enable=1, round=0, i_text=193de3bea0f4e22b9ac68d2ae9f84808, key=Rkey.
  - Next cycle: o_text = a49c7ff2689f352b6b5b ea43026a5049 (no space), Rkey = a0fafe1788542cb123a339392a6c7605.
- REQ-025 Full chain: plaintext 3243f6a8885a308d313198a2e0370734 ^ Rkey at round 0, then rounds 1..9 fed from o_text/Rkey.
  - After the round-9 edge: o_text = 3925841d02dc09fbdc118597196a0b32 and Rkey = KEY.
- REQ-026 Hold: enable=0 for 5 cycles mid-chain -> o_text and Rkey unchanged.
  - Resuming the chain SHALL still yield the REQ-025 ciphertext.
- REQ-027 Back-to-back blocks: a second identical plaintext at round 0 on the cycle after round 9 -> identical ciphertext 10 cycles later.
- REQ-028 Reset asserted at round 5, then a fresh chain -> correct ciphertext.
  - round = 12 with enable=1 -> outputs unchanged.

Source files
------------

// File: rtl/aes.sv
// AES-128 single-round encryption engine with an on-the-fly key schedule.
//
// One call performs one AES round. The parent feeds o_text back to i_text and
// Rkey back to key to chain the ten rounds of a block, one round per clock.
// The initial AddRoundKey is left to the caller (i_text = plaintext ^ Rkey at
// round 0). After the round-9 edge o_text holds the ciphertext, and Rkey is
// reloaded with KEY, so the next block can start on the following cycle.
//
// Byte order: bits [127:120] are byte 0 (row 0, col 0). Bytes are
// column-major, four bytes per column.
//
// Ports
//   clock   in   1    rising-edge clock
//   resetn  in   1    synchronous active-low reset (o_text = 0, Rkey = KEY)
//   enable  in   1    perform one round on this edge
//   i_text  in   128  round input state
//   key     in   128  current round key (normally fed back from Rkey)
//   round   in   4    index of the round key on key; 0..9 valid, 10..15 hold
//   o_text  out  128  registered round output state
//   Rkey    out  128  registered next round key

// Standard AES S-box as a 256x8 ROM.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the top byte, so byte a lives at bit offset 8*(255-a).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 255 - a is ~a for an 8-bit index.
  assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

module aes #(
  parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         enable,
  input  logic [127:0] i_text,
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] o_text,
  output logic [127:0] Rkey
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant for the key produced from round key number r.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  nk_w0, nk_w1, nk_w2, nk_w3;
  logic [127:0] next_key;
  logic         last_round;
  logic         round_valid;

  // State path: SubBytes -> ShiftRows -> MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .a (i_text[127-8*i -: 8]),
      .y (sub_bytes[127-8*i -: 8])
    );
  end

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  always_comb begin
    shift_rows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
  end

  // Key path: SubWord(RotWord(w3)) ^ Rcon, then the xor ripple across words.
  assign rot_word = {key[23:0], key[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a (rot_word[31-8*j -: 8]),
      .y (sub_word[31-8*j -: 8])
    );
  end

  assign nk_w0    = key[127:96] ^ sub_word ^ {rcon(round), 24'h000000};
  assign nk_w1    = key[95:64]  ^ nk_w0;
  assign nk_w2    = key[63:32]  ^ nk_w1;
  assign nk_w3    = key[31:0]   ^ nk_w2;
  assign next_key = {nk_w0, nk_w1, nk_w2, nk_w3};

  assign last_round  = (round == 4'd9);
  assign round_valid = (round <= 4'd9);

  // Round register: the only stage; all outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      o_text <= '0;
      Rkey   <= KEY;
    end else if (enable && round_valid) begin
      o_text <= (last_round ? shift_rows : mix_cols) ^ next_key;
      // After the last round the schedule rewinds so the next block starts clean.
      Rkey   <= last_round ? KEY : next_key;
    end
  end

endmodule

// File: tb/tb_aes.sv
// Directed bench for the single-round AES-128 engine, using the FIPS-197
// Appendix B walkthrough and the SP800-38A ECB-AES128 vectors (same key).
module tb_aes;

  localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK9    = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] PT_A   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R0_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R0_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] PT_1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT_3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT_3   = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PT_4   = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT_4   = 128'h7b0c785e27e8ad3f8223207104725dd4;

  logic         clock;
  logic         resetn;
  logic         enable;
  logic [127:0] i_text;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] o_text;
  logic [127:0] Rkey;

  int n_checks = 0;
  int n_fail   = 0;

  aes #(.KEY(KEY)) dut (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .i_text (i_text),
    .key    (key),
    .round  (round),
    .o_text (o_text),
    .Rkey   (Rkey)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] observed,
                          input logic [127:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Key always comes back from Rkey, as the parent would wire it.
  task automatic drive(input logic en, input logic [3:0] r, input logic [127:0] t);
    enable = en;
    round  = r;
    i_text = t;
    key    = Rkey;
  endtask

  function automatic logic [127:0] noise();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Full ten-round chain with no idle cycles before or after.
  task automatic run_chain(input string tag, input logic [127:0] pt,
                           input logic [127:0] ct);
    for (int r = 0; r < 10; r++) begin
      drive(1'b1, 4'(r), (r == 0) ? (pt ^ Rkey) : o_text);
      step();
      if (r == 8) check_eq({tag, "_rkey9"}, Rkey, RK9);
    end
    check_eq({tag, "_ct"}, o_text, ct);
    check_eq({tag, "_rkey_rewind"}, Rkey, KEY);
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 4'd0, '0);
    step();
    step();
    check_eq("reset_otext", o_text, '0);
    check_eq("reset_rkey", Rkey, KEY);

    // Reset wins over an active round.
    drive(1'b1, 4'd0, R0_IN);
    step();
    check_eq("reset_prio_otext", o_text, '0);
    check_eq("reset_prio_rkey", Rkey, KEY);

    // Single round 0 (FIPS-197 Appendix B, round 1).
    resetn = 1'b1;
    drive(1'b1, 4'd0, R0_IN);
    step();
    check_eq("round0_otext", o_text, R0_OUT);
    check_eq("round0_rkey", Rkey, RK1);

    // Hold with enable low while the inputs wander.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'($urandom_range(0, 9)), noise());
      step();
      check_eq("hold_otext", o_text, R0_OUT);
      check_eq("hold_rkey", Rkey, RK1);
    end

    // Out-of-range round indices are ignored even when enabled.
    drive(1'b1, 4'd12, noise());
    step();
    check_eq("round12_otext", o_text, R0_OUT);
    check_eq("round12_rkey", Rkey, RK1);
    drive(1'b1, 4'd15, noise());
    step();
    check_eq("round15_otext", o_text, R0_OUT);
    check_eq("round15_rkey", Rkey, RK1);

    // Resume the same block through rounds 1..9.
    for (int r = 1; r < 10; r++) begin
      drive(1'b1, 4'(r), o_text);
      step();
      if (r == 8) check_eq("resume_rkey9", Rkey, RK9);
    end
    check_eq("resume_ct", o_text, CT_A);
    check_eq("resume_rkey_rewind", Rkey, KEY);

    // Back-to-back blocks, each starting the cycle after the previous round 9.
    run_chain("ecb1", PT_1, CT_1);
    run_chain("ecb2", PT_2, CT_2);
    run_chain("ecb3", PT_3, CT_3);
    run_chain("fips", PT_A, CT_A);
    run_chain("fips_again", PT_A, CT_A);

    // Abandon a block at round 5 via reset, then encrypt a fresh one.
    for (int r = 0; r < 5; r++) begin
      drive(1'b1, 4'(r), (r == 0) ? (PT_2 ^ Rkey) : o_text);
      step();
    end
    resetn = 1'b0;
    drive(1'b1, 4'd5, o_text);
    step();
    check_eq("midreset_otext", o_text, '0);
    check_eq("midreset_rkey", Rkey, KEY);
    resetn = 1'b1;
    run_chain("after_reset", PT_4, CT_4);

    drive(1'b1, 4'd12, o_text);
    step();
    check_eq("post_round12_otext", o_text, CT_4);
    check_eq("post_round12_rkey", Rkey, KEY);

    drive(1'b0, 4'd0, '0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
